// File: rtl/stream_arb_pkg.sv
// Shared types and limits for the stream arbiter/mux slice.
package stream_arb_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam int MAX_CH = 16;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner search: first requester at or above ptr, wrapping.
module arb_pick #(
  parameter int NUM_CH    = 4,
  parameter int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0]    req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [NUM_CH-1:0]    gnt,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  // One extra bit so ptr+offset never overflows before the wrap compare.
  logic [SEL_WIDTH:0]   sum;
  logic [SEL_WIDTH-1:0] c;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    sum = '0;
    c   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, ptr} + (SEL_WIDTH+1)'(i);
      if (sum >= (SEL_WIDTH+1)'(NUM_CH))
        sum = sum - (SEL_WIDTH+1)'(NUM_CH);
      c = sum[SEL_WIDTH-1:0];
      if (!any && req[c]) begin
        gnt[c] = 1'b1;
        idx    = c;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-to-1 valid/ready stream mux with a one-word registered output stage.
// Define STREAM_ARB_MUX_RR_EN for round-robin; default is fixed lowest-index priority.
module stream_arb_mux
  import stream_arb_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     in_valid,
  input  logic [DATA_WIDTH-1:0] in_data [NUM_CH],
  output logic [NUM_CH-1:0]     in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]  out_sel,
  input  logic                  out_ready
);

  if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_cfg
    $error("stream_arb_mux: NUM_CH out of range");
  end

  state_t               state;
  logic                 slot_free;
  logic [NUM_CH-1:0]    gnt;
  logic [SEL_WIDTH-1:0] idx;
  logic                 any;
  logic [SEL_WIDTH-1:0] ptr;

  arb_pick #(.NUM_CH(NUM_CH), .SEL_WIDTH(SEL_WIDTH)) u_pick (
    .req (in_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign slot_free = (state == EMPTY) | out_ready;
  assign in_ready  = (slot_free && !rst) ? gnt : '0;
  assign out_valid = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
    end else if (slot_free) begin
      if (any) begin
        state    <= FULL;
        out_data <= in_data[idx];
        out_sel  <= idx;
      end else begin
        state <= EMPTY;
      end
    end
  end

`ifdef STREAM_ARB_MUX_RR_EN
  // Pointer moves just past the winner so it has lowest priority next time.
  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (slot_free && any)
      ptr <= (idx == SEL_WIDTH'(NUM_CH-1)) ? '0 : idx + 1'b1;
  end
`else
  assign ptr = '0;
`endif

endmodule

// File: tb/tb_stream_arb_mux.sv
// Directed bench for stream_arb_mux (NUM_CH=4, DATA_WIDTH=32), both arbitration builds.
module tb_stream_arb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data [4];
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_chk  = 0;
  int n_fail = 0;

  stream_arb_mux #(.NUM_CH(4), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  iv;
    logic [31:0] base;
    logic        ordy;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle: in_data[c] = base + c; check in_ready before the edge, outputs after.
  task automatic step(input string tag, input logic r, input logic [3:0] iv, input logic [31:0] base,
                      input logic ordy, input logic [3:0] e_rdy, input logic e_vld,
                      input logic [31:0] e_data, input logic [1:0] e_sel);
    @(negedge clk);
    rst       = r;
    in_valid  = iv;
    out_ready = ordy;
    for (int c = 0; c < 4; c++) in_data[c] = base + 32'(c);
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_vld));
    chk({tag, ".out_data"}, out_data, e_data);
    chk({tag, ".out_sel"}, 32'(out_sel), 32'(e_sel));
  endtask

  logic [1:0] rr_exp [5];

  initial begin
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) in_data[c] = '0;

    vt[0] = '{1'b1, 4'b1111, 32'h0,        1'b0, 4'b0000, 1'b0, 32'h0,        2'd0};
    vt[1] = '{1'b0, 4'b0100, 32'hDEADBEED, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    vt[2] = '{1'b0, 4'b0001, 32'h100,      1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd2};
    vt[3] = '{1'b0, 4'b0001, 32'h100,      1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd2};
    vt[4] = '{1'b0, 4'b0001, 32'h100,      1'b0, 4'b0000, 1'b1, 32'hDEADBEEF, 2'd2};
    vt[5] = '{1'b0, 4'b0000, 32'h0,        1'b1, 4'b0000, 1'b0, 32'hDEADBEEF, 2'd2};
    vt[6] = '{1'b0, 4'b0001, 32'h10,       1'b0, 4'b0001, 1'b1, 32'h10,       2'd0};
    vt[7] = '{1'b0, 4'b1010, 32'h20,       1'b1, 4'b0010, 1'b1, 32'h21,       2'd1};
`ifdef STREAM_ARB_MUX_RR_EN
    vt[8] = '{1'b0, 4'b1010, 32'h30,       1'b1, 4'b1000, 1'b1, 32'h33,       2'd3};
    rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`else
    vt[8] = '{1'b0, 4'b1010, 32'h30,       1'b1, 4'b0010, 1'b1, 32'h31,       2'd1};
    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    vt[9] = '{1'b1, 4'b1111, 32'h40,       1'b0, 4'b0000, 1'b0, 32'h0,        2'd0};

    for (int i = 0; i < 10; i++)
      step($sformatf("vec%0d", i), vt[i].r, vt[i].iv, vt[i].base, vt[i].ordy,
           vt[i].e_rdy, vt[i].e_vld, vt[i].e_data, vt[i].e_sel);

    // All channels requesting continuously after reset: arbitration order.
    for (int k = 0; k < 5; k++)
      step($sformatf("arb%0d", k), 1'b0, 4'b1111, 32'h50, 1'b1,
           4'b0001 << rr_exp[k], 1'b1, 32'h50 + 32'(rr_exp[k]), rr_exp[k]);

    // Channel 1 streams 1..8 back-to-back with no bubbles.
    for (int k = 1; k <= 8; k++)
      step($sformatf("thru%0d", k), 1'b0, 4'b0010, 32'(k) - 32'd1, 1'b1,
           4'b0010, 1'b1, 32'(k), 2'd1);
    step("drain", 1'b0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b0, 32'd8, 2'd1);

    // Mid-stream reset with a word held; arbitration restarts at channel 0.
    step("load5", 1'b0, 4'b0100, 32'h3, 1'b1, 4'b0100, 1'b1, 32'h5, 2'd2);
    step("hold5", 1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, 32'h5, 2'd2);
    step("rstmid", 1'b1, 4'b1111, 32'h60, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0);
    step("postrst", 1'b0, 4'b1111, 32'h70, 1'b1, 4'b0001, 1'b1, 32'h70, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
